// File: rtl/kf_seq_pkg.sv
// rtl/kf_seq_pkg.sv - shared constants, state encoding and default coefficient table for kf_seq_ctrl
package kf_seq_pkg;

  localparam int W           = 24;
  localparam int FRAC        = 14;
  localparam int NCOEF       = 20;
  localparam int DEF_LOOP    = 20;
  localparam int DEF_TIMEOUT = 1024;

  // Coefficient index width and the table size in that width, for compare-without-extension
  localparam int AW = 5;
  localparam logic [AW-1:0] NCOEF_A = AW'(NCOEF);

  // 1.0 in sign-magnitude with FRAC fractional bits
  localparam logic [W-1:0] COEF_ONE = W'(1 << FRAC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_MEAS,
    ST_WAIT_RES,
    ST_OUT
  } seq_state_t;

  // Power-up coefficient table: x1,x2,p11..p22,phi11..phi22,q11..q22,h1,h2,R,g1,g2,u
  function automatic logic [W-1:0] kf_coef_default(input int idx);
    case (idx)
      1:               return 24'h0001EB;  // 0.03
      2, 5, 6, 9, 14:  return COEF_ONE;    // 1.0
      7, 16:           return 24'h000666;  // 0.1
      10, 13:          return 24'h0000A4;  // 0.01
      default:         return '0;
    endcase
  endfunction

endpackage

// File: rtl/kf_seq_ctrl_if.sv
// rtl/kf_seq_ctrl_if.sv - host, stream and core-side signal bundle of the Kalman sequencer
interface kf_seq_ctrl_if;
  import kf_seq_pkg::*;

  logic                run;
  logic                reinit;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [W-1:0]        cfg_wdata;
  logic [W-1:0]        cfg_rdata;
  logic                meas_valid;
  logic [W-1:0]        meas_data;
  logic                meas_ready;
  logic                res_valid;
  logic [W-1:0]        res_data;
  logic                res_ready;
  logic                core_start;
  logic [W-1:0]        core_data_in;
  logic [7:0]          core_loop_addr;
  logic [W-1:0]        core_data_out;
  logic                core_valid;
  logic                busy;
  logic [15:0]         sample_cnt;
  logic                err_spurious;
  logic                err_timeout;
  logic                err_clr;

  // Sequencer side
  modport slave (
    input  run, reinit, cfg_we, cfg_addr, cfg_wdata, meas_valid, meas_data,
           res_ready, core_data_out, core_valid, err_clr,
    output cfg_rdata, meas_ready, res_valid, res_data, core_start, core_data_in,
           core_loop_addr, busy, sample_cnt, err_spurious, err_timeout
  );

  // Host / core / environment side
  modport master (
    output run, reinit, cfg_we, cfg_addr, cfg_wdata, meas_valid, meas_data,
           res_ready, core_data_out, core_valid, err_clr,
    input  cfg_rdata, meas_ready, res_valid, res_data, core_start, core_data_in,
           core_loop_addr, busy, sample_cnt, err_spurious, err_timeout
  );

endinterface

// File: rtl/kf_seq_coef_rf.sv
// rtl/kf_seq_coef_rf.sv - coefficient register file with host read port and burst snapshot
module kf_seq_coef_rf
  import kf_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [W-1:0]   wdata,
  input  logic [AW-1:0]  raddr,
  output logic [W-1:0]   rdata,
  input  logic           snap_capture,
  input  logic [AW-1:0]  snap_addr,
  output logic [W-1:0]   snap_data
);

  logic [W-1:0] coef [NCOEF];
  logic [W-1:0] snap [NCOEF];

  // Host-visible table; out-of-range writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= kf_coef_default(i);
    end else if (we && (waddr < NCOEF_A)) begin
      coef[waddr] <= wdata;
    end
  end

  // Burst copy frozen at LOAD entry so host writes mid-burst only affect the next burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) snap[i] <= '0;
    end else if (snap_capture) begin
      snap <= coef;
    end
  end

  // Registered host read; a same-cycle write is not yet visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= (raddr < NCOEF_A) ? coef[raddr] : '0;
  end

  assign snap_data = (snap_addr < NCOEF_A) ? snap[snap_addr] : '0;

endmodule

// File: rtl/kf_seq_ctrl.sv
// rtl/kf_seq_ctrl.sv - Kalman core sequencer top; KF_SEQ_WDOG_EN enables the WAIT_RES watchdog
module kf_seq_ctrl
  import kf_seq_pkg::*;
#(
  parameter int LOOP_ADDR = DEF_LOOP,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  kf_seq_ctrl_if.slave  bus
);

  seq_state_t     state;
  logic [AW-1:0]  idx;
  logic           core_start_q;
  logic [W-1:0]   core_data_q;
  logic [7:0]     loop_q;
  logic           res_valid_q;
  logic [W-1:0]   res_data_q;
  logic [15:0]    cnt_q;
  logic           spur_q;
  logic           meas_rdy;
  logic           load_enter;
  logic           timeout_hit;
  logic [W-1:0]   snap_data;

  assign meas_rdy   = (state == ST_WAIT_MEAS) && !bus.reinit;
  assign load_enter = bus.reinit || ((state == ST_IDLE) && bus.run) || timeout_hit;

  kf_seq_coef_rf u_rf (
    .clk          (clk),
    .rst_n        (rst_n),
    .we           (bus.cfg_we),
    .waddr        (bus.cfg_addr),
    .wdata        (bus.cfg_wdata),
    .raddr        (bus.cfg_addr),
    .rdata        (bus.cfg_rdata),
    .snap_capture (load_enter),
    .snap_addr    (idx),
    .snap_data    (snap_data)
  );

`ifdef KF_SEQ_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            tout_q;

  // Cycles spent in WAIT_RES without a core result; zero whenever outside WAIT_RES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wd_cnt <= '0;
    else if (state != ST_WAIT_RES)  wd_cnt <= '0;
    else if (!bus.core_valid)       wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign timeout_hit = (state == ST_WAIT_RES) && !bus.core_valid &&
                       (wd_cnt == WD_W'(TIMEOUT - 1));

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            tout_q <= 1'b0;
    else if (timeout_hit)  tout_q <= 1'b1;
    else if (bus.err_clr)  tout_q <= 1'b0;
  end

  assign bus.err_timeout = tout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Sequencer FSM: init burst, measurement handshake, result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      loop_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      cnt_q        <= '0;
    end else if (load_enter) begin
      // Word 0 of the burst: START pulse with zero data
      state        <= ST_LOAD;
      idx          <= '0;
      core_start_q <= 1'b1;
      core_data_q  <= '0;
      loop_q       <= 8'(LOOP_ADDR);
      res_valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          core_start_q <= 1'b0;
          if (idx == NCOEF_A) begin
            state <= ST_WAIT_MEAS;
          end else begin
            core_data_q <= snap_data;
            idx         <= idx + AW'(1);
          end
        end
        ST_WAIT_MEAS: begin
          if (bus.meas_valid && meas_rdy) begin
            core_data_q <= bus.meas_data;
            state       <= ST_WAIT_RES;
          end else if (!bus.run) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_RES: begin
          if (bus.core_valid) begin
            res_data_q  <= bus.core_data_out;
            res_valid_q <= 1'b1;
            cnt_q       <= cnt_q + 16'd1;
            state       <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= bus.run ? ST_WAIT_MEAS : ST_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky flag for core results arriving when none is expected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          spur_q <= 1'b0;
    else if (bus.core_valid && (state != ST_WAIT_RES))   spur_q <= 1'b1;
    else if (bus.err_clr)                                spur_q <= 1'b0;
  end

  assign bus.meas_ready     = meas_rdy;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_data       = res_data_q;
  assign bus.core_start     = core_start_q;
  assign bus.core_data_in   = core_data_q;
  assign bus.core_loop_addr = loop_q;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.sample_cnt     = cnt_q;
  assign bus.err_spurious   = spur_q;

endmodule

// File: tb/tb_kf_seq_ctrl.sv
// tb/tb_kf_seq_ctrl.sv - self-checking bench for kf_seq_ctrl with a queue-based reference model
module tb_kf_seq_ctrl;

  localparam int TMO = 16;
  localparam int P_IDLE = 0, P_LOAD = 1, P_MEAS = 2, P_RES = 3, P_OUT = 4;

  localparam logic [23:0] DEF [20] = '{
    24'h000000, 24'h0001EB, 24'h004000, 24'h000000, 24'h000000,
    24'h004000, 24'h004000, 24'h000666, 24'h000000, 24'h004000,
    24'h0000A4, 24'h000000, 24'h000000, 24'h0000A4, 24'h004000,
    24'h000000, 24'h000666, 24'h000000, 24'h000000, 24'h000000
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  kf_seq_ctrl_if bus ();

  kf_seq_ctrl #(.LOOP_ADDR(20), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [23:0] mcoef [20];
  logic [23:0] burst_q [$];
  int          m_ph;
  int          m_wd;
  logic        e_start, e_rv, e_spur, e_tout;
  logic [23:0] e_data, e_rdata, e_cfg;
  logic [7:0]  e_loop;
  logic [15:0] e_cnt;

  task automatic m_reset();
    for (int i = 0; i < 20; i++) mcoef[i] = DEF[i];
    burst_q.delete();
    m_ph = P_IDLE; m_wd = 0;
    e_start = 0; e_rv = 0; e_spur = 0; e_tout = 0;
    e_data = 0; e_rdata = 0; e_cfg = 0; e_loop = 0; e_cnt = 0;
  endtask

  task automatic m_enter_load();
    burst_q.delete();
    for (int i = 0; i < 20; i++) burst_q.push_back(mcoef[i]);
    e_start = 1; e_data = 0; e_loop = 8'd20; e_rv = 0;
    m_ph = P_LOAD;
  endtask

  task automatic m_step();
    logic [23:0] n_cfg;
    logic        spur_set, tout_set;
    n_cfg    = (bus.cfg_addr < 5'd20) ? mcoef[bus.cfg_addr] : 24'h0;
    spur_set = bus.core_valid && (m_ph != P_RES);
    tout_set = 1'b0;
    if (bus.reinit) m_enter_load();
    else begin
      case (m_ph)
        P_IDLE: if (bus.run) m_enter_load();
        P_LOAD: begin
          if (burst_q.size() != 0) begin
            e_start = 0;
            e_data  = burst_q.pop_front();
          end else m_ph = P_MEAS;
        end
        P_MEAS: begin
          if (bus.meas_valid) begin
            e_data = bus.meas_data; m_ph = P_RES; m_wd = 0;
          end else if (!bus.run) m_ph = P_IDLE;
        end
        P_RES: begin
          if (bus.core_valid) begin
            e_rv = 1; e_rdata = bus.core_data_out; e_cnt = e_cnt + 16'd1; m_ph = P_OUT;
          end
`ifdef KF_SEQ_WDOG_EN
          else begin
            m_wd++;
            if (m_wd == TMO) begin
              tout_set = 1'b1;
              m_enter_load();
            end
          end
`endif
        end
        default: if (bus.res_ready) begin
          e_rv = 0; m_ph = bus.run ? P_MEAS : P_IDLE;
        end
      endcase
    end
    if (bus.cfg_we && (bus.cfg_addr < 5'd20)) mcoef[bus.cfg_addr] = bus.cfg_wdata;
    e_cfg = n_cfg;
    if (spur_set) e_spur = 1; else if (bus.err_clr) e_spur = 0;
    if (tout_set) e_tout = 1; else if (bus.err_clr) e_tout = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", bus.busy, m_ph != P_IDLE);
      chk("meas_ready", bus.meas_ready, (m_ph == P_MEAS) && !bus.reinit);
      chk("core_start", bus.core_start, e_start);
      chk("core_data_in", bus.core_data_in, e_data);
      chk("core_loop_addr", bus.core_loop_addr, e_loop);
      chk("res_valid", bus.res_valid, e_rv);
      if (e_rv) chk("res_data", bus.res_data, e_rdata);
      chk("sample_cnt", bus.sample_cnt, e_cnt);
      chk("err_spurious", bus.err_spurious, e_spur);
      chk("err_timeout", bus.err_timeout, e_tout);
      chk("cfg_rdata", bus.cfg_rdata, e_cfg);
    end
  end

  logic [23:0] burst [21];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic collect_burst();
    for (int k = 1; k <= 20; k++) begin
      tick();
      burst[k] = bus.core_data_in;
      chk("burst_start_low", bus.core_start, 0);
    end
  endtask

  initial begin
    int n;
    bus.run = 0; bus.reinit = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0;
    bus.meas_valid = 0; bus.meas_data = 0; bus.res_ready = 0;
    bus.core_data_out = 0; bus.core_valid = 0; bus.err_clr = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_loop_addr", bus.core_loop_addr, 0);
    chk("rst_sample_cnt", bus.sample_cnt, 0);
    chk("rst_meas_ready", bus.meas_ready, 0);
    chk("rst_err_spurious", bus.err_spurious, 0);
    rst_n = 1;

    // 1: default init burst
    bus.run = 1;
    tick();
    chk("t1_start", bus.core_start, 1);
    chk("t1_word0", bus.core_data_in, 0);
    chk("t1_loop_addr", bus.core_loop_addr, 20);
    collect_burst();
    chk("t1_word2", burst[2], 24'h0001EB);
    chk("t1_word3", burst[3], 24'h004000);
    chk("t1_word8", burst[8], 24'h000666);
    chk("t1_word11", burst[11], 24'h0000A4);
    chk("t1_word17", burst[17], 24'h000666);
    tick();
    chk("t1_meas_ready", bus.meas_ready, 1);

    // 2: coefficient write, read-back latency, reinit burst
    bus.cfg_we = 1; bus.cfg_addr = 16; bus.cfg_wdata = 24'h000CCD;
    tick();
    bus.cfg_we = 0;
    chk("t2_rd_old", bus.cfg_rdata, 24'h000666);
    tick();
    chk("t2_rd_new", bus.cfg_rdata, 24'h000CCD);
    bus.cfg_addr = 25;
    tick();
    chk("t2_rd_oob", bus.cfg_rdata, 0);
    bus.reinit = 1;
    tick();
    bus.reinit = 0;
    chk("t2_start", bus.core_start, 1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin bus.cfg_we = 1; bus.cfg_addr = 10; bus.cfg_wdata = 24'h000111; end
      tick();
      bus.cfg_we = 0;
      burst[k] = bus.core_data_in;
    end
    chk("t2_word17", burst[17], 24'h000CCD);
    chk("t2_word11_snapshot", burst[11], 24'h0000A4);
    tick();

    // 3: one measurement / result
    bus.meas_valid = 1; bus.meas_data = 24'h004000;
    tick();
    bus.meas_valid = 0;
    chk("t3_core_data_in", bus.core_data_in, 24'h004000);
    chk("t3_meas_ready", bus.meas_ready, 0);
    repeat (3) tick();
    bus.core_valid = 1; bus.core_data_out = 24'h003800;
    tick();
    bus.core_valid = 0;
    chk("t3_res_valid", bus.res_valid, 1);
    chk("t3_res_data", bus.res_data, 24'h003800);
    chk("t3_sample_cnt", bus.sample_cnt, 1);

    // 4: backpressure, spurious core_valid, clear priority
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin bus.core_valid = 1; bus.core_data_out = 24'h007777; bus.err_clr = 1; end
      if (i == 5) bus.err_clr = 1;
      if (i == 6) begin bus.core_valid = 1; bus.core_data_out = 24'h001111; end
      tick();
      bus.core_valid = 0; bus.err_clr = 0;
      chk("t4_res_valid", bus.res_valid, 1);
      chk("t4_res_data", bus.res_data, 24'h003800);
      chk("t4_meas_ready", bus.meas_ready, 0);
      if (i == 4) chk("t4_spur_set_wins", bus.err_spurious, 1);
      if (i == 5) chk("t4_spur_cleared", bus.err_spurious, 0);
      if (i == 6) chk("t4_spur_again", bus.err_spurious, 1);
    end
    bus.res_ready = 1;
    tick();
    bus.res_ready = 0;
    chk("t4_res_released", bus.res_valid, 0);
    chk("t4_back_to_meas", bus.meas_ready, 1);

    // 5: reinit collides with a measurement offer
    bus.meas_valid = 1; bus.meas_data = 24'h005555; bus.reinit = 1;
    #1;
    chk("t5_ready_masked", bus.meas_ready, 0);
    tick();
    bus.reinit = 0; bus.meas_valid = 0;
    chk("t5_start", bus.core_start, 1);
    chk("t5_word0", bus.core_data_in, 0);
    collect_burst();
    chk("t5_word11_new", burst[11], 24'h000111);
    chk("t5_word17", burst[17], 24'h000CCD);
    tick();

    // drain to IDLE with run low
    bus.meas_valid = 1; bus.meas_data = 24'h000100;
    tick();
    bus.meas_valid = 0; bus.core_valid = 1; bus.core_data_out = 24'h000200;
    tick();
    bus.core_valid = 0; bus.run = 0; bus.res_ready = 1;
    tick();
    bus.res_ready = 0;
    chk("drain_idle", bus.busy, 0);
    chk("drain_cnt", bus.sample_cnt, 2);
    tick();
    chk("drain_stays_idle", bus.busy, 0);

    // 6: watchdog (or endless wait without it)
    bus.run = 1;
    repeat (22) tick();
    chk("t6_meas_ready", bus.meas_ready, 1);
    bus.meas_valid = 1; bus.meas_data = 24'h000300;
    tick();
    bus.meas_valid = 0;
`ifdef KF_SEQ_WDOG_EN
    n = 0;
    while (!bus.err_timeout && n < 40) begin
      tick();
      n++;
    end
    chk("t6_timeout_cycles", n, TMO);
    chk("t6_timeout_flag", bus.err_timeout, 1);
    chk("t6_reload_start", bus.core_start, 1);
    bus.err_clr = 1;
    tick();
    bus.err_clr = 0;
    chk("t6_timeout_clear", bus.err_timeout, 0);
    bus.run = 0;
    repeat (25) tick();
    chk("t6_idle", bus.busy, 0);
    chk("t6_cnt", bus.sample_cnt, 2);
`else
    n = 0;
    repeat (30) begin
      tick();
      n++;
    end
    chk("t6_still_waiting", bus.busy, 1);
    chk("t6_no_timeout", bus.err_timeout, 0);
    chk("t6_no_result", bus.res_valid, 0);
    bus.core_valid = 1; bus.core_data_out = 24'h000400;
    tick();
    bus.core_valid = 0; bus.run = 0; bus.res_ready = 1;
    tick();
    bus.res_ready = 0;
    chk("t6_idle", bus.busy, 0);
    chk("t6_cnt", bus.sample_cnt, 3);
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
